// File: rtl/debouncing_synchronizer.sv
// Multi-channel synchronizer: flop chain, persistence filter, edge detector.
// Rise/Fall/Glitch/Any_event are single-cycle registered pulses.
module debouncing_synchronizer #(
    parameter int                     CHANNELS      = 4,
    parameter int                     STAGES        = 2,
    parameter int                     FILTER_CYCLES = 4,
    parameter logic [CHANNELS-1:0]    INIT_LEVEL    = '0
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic [CHANNELS-1:0] Bits_in,
    output logic [CHANNELS-1:0] Sync,
    output logic [CHANNELS-1:0] Filtered,
    output logic [CHANNELS-1:0] Rise,
    output logic [CHANNELS-1:0] Fall,
    output logic [CHANNELS-1:0] Glitch,
    output logic                Any_event
);

    generate
        if (CHANNELS < 1) begin : g_bad_channels
            $error("CHANNELS must be >= 1");
        end
        if (STAGES < 2) begin : g_bad_stages
            $error("STAGES must be >= 2");
        end
        if (FILTER_CYCLES < 1) begin : g_bad_filter
            $error("FILTER_CYCLES must be >= 1");
        end
    endgenerate

    localparam int CW = $clog2(FILTER_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_CYCLES - 1);

    (* ASYNC_REG = "TRUE" *) logic [CHANNELS-1:0] sr_q [STAGES];
    logic [CHANNELS-1:0] sr_d [STAGES];

    logic [CW-1:0]       cnt_q [CHANNELS];
    logic [CW-1:0]       cnt_d [CHANNELS];
    logic [CHANNELS-1:0] filt_q, filt_d;
    logic [CHANNELS-1:0] rise_q, rise_d;
    logic [CHANNELS-1:0] fall_q, fall_d;
    logic [CHANNELS-1:0] glitch_q, glitch_d;
    logic                any_q, any_d;
    logic [CHANNELS-1:0] sync_w;

    assign sync_w = sr_q[STAGES-1];

    always_comb begin
        sr_d[0] = Bits_in;
        for (int i = 1; i < STAGES; i++) begin
            sr_d[i] = sr_q[i-1];
        end
    end

    // A pending change is abandoned when Sync falls back to Filtered mid-count.
    always_comb begin
        filt_d   = filt_q;
        glitch_d = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            cnt_d[c] = cnt_q[c];
            if (sync_w[c] == filt_q[c]) begin
                cnt_d[c]    = '0;
                glitch_d[c] = (cnt_q[c] != '0);
            end else if (cnt_q[c] == CNT_MAX) begin
                filt_d[c] = sync_w[c];
                cnt_d[c]  = '0;
            end else begin
                cnt_d[c] = cnt_q[c] + CW'(1);
            end
        end
        rise_d = filt_d & ~filt_q;
        fall_d = ~filt_d & filt_q;
        any_d  = |(rise_d | fall_d);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < STAGES; i++) begin
                sr_q[i] <= INIT_LEVEL;
            end
            for (int c = 0; c < CHANNELS; c++) begin
                cnt_q[c] <= '0;
            end
            filt_q   <= INIT_LEVEL;
            rise_q   <= '0;
            fall_q   <= '0;
            glitch_q <= '0;
            any_q    <= 1'b0;
        end else begin
            sr_q     <= sr_d;
            cnt_q    <= cnt_d;
            filt_q   <= filt_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            glitch_q <= glitch_d;
            any_q    <= any_d;
        end
    end

    assign Sync      = sync_w;
    assign Filtered  = filt_q;
    assign Rise      = rise_q;
    assign Fall      = fall_q;
    assign Glitch    = glitch_q;
    assign Any_event = any_q;

endmodule

// File: tb/tb_debouncing_synchronizer.sv
// Bench for debouncing_synchronizer: two instances (INIT 0 and 1010),
// directed steps then random bursts, against a run-length reference model.
module tb_debouncing_synchronizer;

    localparam int ST = 2;
    localparam int FC = 4;
    localparam logic [3:0] INIT_B = 4'b1010;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] bits = '0;

    logic [3:0] sync_a, filt_a, rise_a, fall_a, glit_a;
    logic [3:0] sync_b, filt_b, rise_b, fall_b, glit_b;
    logic       any_a, any_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    debouncing_synchronizer #(
        .CHANNELS(4), .STAGES(ST), .FILTER_CYCLES(FC), .INIT_LEVEL(4'b0000)
    ) dut_a (
        .Clock(clk), .Reset(rst), .Bits_in(bits),
        .Sync(sync_a), .Filtered(filt_a), .Rise(rise_a),
        .Fall(fall_a), .Glitch(glit_a), .Any_event(any_a)
    );

    debouncing_synchronizer #(
        .CHANNELS(4), .STAGES(ST), .FILTER_CYCLES(FC), .INIT_LEVEL(INIT_B)
    ) dut_b (
        .Clock(clk), .Reset(rst), .Bits_in(bits),
        .Sync(sync_b), .Filtered(filt_b), .Rise(rise_b),
        .Fall(fall_b), .Glitch(glit_b), .Any_event(any_b)
    );

    // Reference: delay line of input samples; v=0 marks a reset-filled slot.
    typedef struct packed {
        logic       v;
        logic [3:0] b;
    } samp_t;

    samp_t      dq[$];
    logic [3:0] m_sync[2], m_filt[2], m_rise[2], m_fall[2], m_glit[2];
    logic       m_any[2];
    int         m_run[2][4];

    function automatic logic [3:0] init_of(input int i);
        return (i == 0) ? 4'b0000 : INIT_B;
    endfunction

    function automatic logic [3:0] head(input int i);
        return dq[0].v ? dq[0].b : init_of(i);
    endfunction

    task automatic model_edge(input logic r, input logic [3:0] b);
        logic [3:0] s, nf;
        if (r) begin
            dq.delete();
            for (int k = 0; k < ST; k++) dq.push_back('{v: 1'b0, b: 4'b0});
            for (int i = 0; i < 2; i++) begin
                m_filt[i] = init_of(i);
                m_rise[i] = '0;
                m_fall[i] = '0;
                m_glit[i] = '0;
                m_any[i]  = 1'b0;
                for (int c = 0; c < 4; c++) m_run[i][c] = 0;
                m_sync[i] = init_of(i);
            end
            return;
        end
        for (int i = 0; i < 2; i++) begin
            s = head(i);
            nf = m_filt[i];
            m_glit[i] = '0;
            for (int c = 0; c < 4; c++) begin
                if (s[c] == m_filt[i][c]) begin
                    m_glit[i][c] = (m_run[i][c] > 0);
                    m_run[i][c] = 0;
                end else begin
                    m_run[i][c]++;
                    if (m_run[i][c] == FC) begin
                        nf[c] = s[c];
                        m_run[i][c] = 0;
                    end
                end
            end
            m_rise[i] = nf & ~m_filt[i];
            m_fall[i] = ~nf & m_filt[i];
            m_any[i]  = |(m_rise[i] | m_fall[i]);
            m_filt[i] = nf;
        end
        dq.push_back('{v: 1'b1, b: b});
        void'(dq.pop_front());
        for (int i = 0; i < 2; i++) m_sync[i] = head(i);
    endtask

    task automatic chk(input string tag, input logic [3:0] obs,
                       input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %b want %b", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic [3:0] b);
        rst  = r;
        bits = b;
        @(posedge clk);
        model_edge(r, b);
        #1;
        chk("sync_a", sync_a, m_sync[0]);
        chk("filt_a", filt_a, m_filt[0]);
        chk("rise_a", rise_a, m_rise[0]);
        chk("fall_a", fall_a, m_fall[0]);
        chk("glit_a", glit_a, m_glit[0]);
        chk("any_a", {3'b0, any_a}, {3'b0, m_any[0]});
        chk("sync_b", sync_b, m_sync[1]);
        chk("filt_b", filt_b, m_filt[1]);
        chk("rise_b", rise_b, m_rise[1]);
        chk("fall_b", fall_b, m_fall[1]);
        chk("glit_b", glit_b, m_glit[1]);
        chk("any_b", {3'b0, any_b}, {3'b0, m_any[1]});
    endtask

    logic [3:0] rv;
    int         len;

    initial begin
        repeat (3) step(1'b1, 4'b0000);
        chk("rst_filt_a", filt_a, 4'b0000);
        chk("rst_filt_b", filt_b, INIT_B);
        repeat (20) step(1'b0, 4'b0000);

        for (int i = 1; i <= 10; i++) begin
            step(1'b0, 4'b0001);
            if (i == 2) chk("lat_sync0", sync_a, 4'b0001);
            if (i == 5) chk("lat_filt0_early", filt_a, 4'b0000);
            if (i == 6) chk("lat_rise0", rise_a, 4'b0001);
            if (i == 7) chk("rise0_once", rise_a, 4'b0000);
        end
        for (int i = 1; i <= 10; i++) begin
            step(1'b0, 4'b0000);
            if (i == 6) chk("lat_fall0", fall_a, 4'b0001);
        end

        for (int i = 1; i <= 12; i++) begin
            step(1'b0, (i <= 3) ? 4'b0010 : 4'b0000);
            if (i == 6) chk("short_glitch1", glit_a, 4'b0010);
        end
        for (int i = 1; i <= 14; i++) step(1'b0, (i <= 4) ? 4'b0010 : 4'b0000);

        for (int i = 0; i < 50; i++) step(1'b0, (i % 2 == 0) ? 4'b0100 : 4'b0000);
        chk("toggle_filt2", filt_a, 4'b0000);
        repeat (6) step(1'b0, 4'b0000);

        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 4'b1111);
            if (i == 6) chk("all_rise", rise_a, 4'b1111);
        end

        step(1'b1, 4'b1010);
        repeat (8) step(1'b0, 4'b1010);
        repeat (4) step(1'b0, 4'b1011);
        step(1'b1, 4'b1011);
        chk("mid_rst_filt_b", filt_b, INIT_B);
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 4'b1011);
            if (i <= 2) chk("no_edge_b", rise_b | fall_b, 4'b0000);
            if (i == 5) chk("restart_early", rise_b, 4'b0000);
            if (i == 6) chk("restart_rise0", rise_b, 4'b0001);
        end

        for (int n = 0; n < 80; n++) begin
            rv  = 4'($urandom);
            len = $urandom_range(1, 6);
            for (int k = 0; k < len; k++) step($urandom_range(0, 99) < 2, rv);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
